// File: rtl/rom_access_arbiter_if.sv
// rom_access_arbiter_if: fetch/load request ports and ROM port of the shared instruction ROM arbiter.
interface rom_access_arbiter_if;
    logic        i_req;
    logic [31:0] i_addr;
    logic        i_gnt;
    logic        i_rvalid;
    logic [31:0] i_rdata;
    logic        i_err;
    logic        d_req;
    logic [31:0] d_addr;
    logic        d_gnt;
    logic        d_rvalid;
    logic [31:0] d_rdata;
    logic        d_err;
    logic [31:0] rom_addr;
    logic [31:0] rom_data;
    logic        rom_accessable;
    logic        busy;
    modport slave (
        input  i_req, i_addr, d_req, d_addr, rom_data, rom_accessable,
        output i_gnt, i_rvalid, i_rdata, i_err, d_gnt, d_rvalid, d_rdata, d_err, rom_addr, busy
    );
    modport master (
        output i_req, i_addr, d_req, d_addr, rom_data, rom_accessable,
        input  i_gnt, i_rvalid, i_rdata, i_err, d_gnt, d_rvalid, d_rdata, d_err, rom_addr, busy
    );
endinterface

// File: rtl/rom_access_arbiter.sv
// rom_access_arbiter: shares one combinational ROM between fetch and load with wait states.
// ROM_ARB_ROUND_ROBIN_EN selects round-robin arbitration instead of load priority with anti-starvation.
module rom_access_arbiter #(
    parameter int WAIT_CYCLES  = 1,
    parameter int STARVE_LIMIT = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    rom_access_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
    state_t      r_state, w_next;
    logic [31:0] r_addr_q, r_rom_addr, r_i_rdata, r_d_rdata, w_gaddr, w_word;
    logic [3:0]  r_wcnt;
    logic        r_own_q, r_i_rvalid, r_d_rvalid, r_i_err, r_d_err, r_busy;
    logic        w_arb, w_pick_d, w_gnt_i, w_gnt_d, w_gnt, w_done;

    assign w_arb = r_state != ACCESS;

`ifdef ROM_ARB_ROUND_ROBIN_EN
    logic r_rr_last;
    assign w_pick_d = ~bus.i_req | ~r_rr_last;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_rr_last <= 1'b0;
        else if (w_gnt) r_rr_last <= w_gnt_d;
    end
`else
    localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);
    logic [7:0] r_stall_cnt;
    assign w_pick_d = ~bus.i_req | (r_stall_cnt != LIMIT);
    // counts load wins over a waiting fetch; saturates so fetch stays forced until served
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_stall_cnt <= '0;
        else if (w_gnt_i) r_stall_cnt <= '0;
        else if (w_gnt_d && bus.i_req && r_stall_cnt != LIMIT) r_stall_cnt <= r_stall_cnt + 8'd1;
    end
`endif

    assign w_done  = (r_state == ACCESS) && (r_wcnt == 4'd0);
    assign w_word  = bus.rom_accessable ? bus.rom_data : '0;
    assign w_gaddr = w_gnt_d ? bus.d_addr : bus.i_addr;

    always_comb begin
        w_gnt_d = w_arb & bus.d_req & w_pick_d;
        w_gnt_i = w_arb & bus.i_req & ~w_gnt_d;
        w_gnt   = w_gnt_i | w_gnt_d;
        w_next  = w_gnt ? ACCESS : w_done ? RESP : (r_state == ACCESS) ? ACCESS : IDLE;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= IDLE;
            r_addr_q   <= '0;
            r_own_q    <= 1'b0;
            r_wcnt     <= '0;
            r_rom_addr <= '0;
            r_i_rvalid <= 1'b0;
            r_d_rvalid <= 1'b0;
            r_i_rdata  <= '0;
            r_d_rdata  <= '0;
            r_i_err    <= 1'b0;
            r_d_err    <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_gnt) begin
                r_addr_q <= w_gaddr;
                r_own_q  <= w_gnt_d;
                r_wcnt   <= 4'(WAIT_CYCLES);
            end else if (r_state == ACCESS && r_wcnt != 4'd0) begin
                r_wcnt <= r_wcnt - 4'd1;
            end
            r_rom_addr <= w_gnt ? w_gaddr : (w_done || r_state != ACCESS) ? '0 : r_addr_q;
            r_i_rvalid <= w_done & ~r_own_q;
            r_d_rvalid <= w_done & r_own_q;
            r_i_rdata  <= (w_done & ~r_own_q) ? w_word : '0;
            r_d_rdata  <= (w_done & r_own_q) ? w_word : '0;
            r_i_err    <= w_done & ~r_own_q & ~bus.rom_accessable;
            r_d_err    <= w_done & r_own_q & ~bus.rom_accessable;
            r_busy     <= w_next != IDLE;
        end
    end

    assign bus.i_gnt    = w_gnt_i;
    assign bus.d_gnt    = w_gnt_d;
    assign bus.rom_addr = r_rom_addr;
    assign bus.i_rvalid = r_i_rvalid;
    assign bus.i_rdata  = r_i_rdata;
    assign bus.i_err    = r_i_err;
    assign bus.d_rvalid = r_d_rvalid;
    assign bus.d_rdata  = r_d_rdata;
    assign bus.d_err    = r_d_err;
    assign bus.busy     = r_busy;
endmodule
